// File: rtl/mem_read_requester.sv
// Read initiator: issues a burst of reads while keeping at most MAX_OUT outstanding,
// reorders the out-of-order controller responses and streams them in issue order.
module mem_read_requester #(
    parameter int unsigned MAX_OUT = 4,
    parameter int unsigned AW      = 8,
    parameter int unsigned DW      = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [7:0]    count,
    output logic          req_en,
    output logic [AW-1:0] req_addr,
    input  logic          resp_flag,
    input  logic [AW-1:0] resp_addr,
    input  logic [DW-1:0] resp_data,
    output logic          out_valid,
    output logic [AW-1:0] out_addr,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int unsigned IW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t state, state_next;

    logic [AW-1:0] base;
    logic [7:0]    total;
    logic [7:0]    issued;
    logic [7:0]    retired;
    logic [IW-1:0] hp;
    logic          slot_valid [MAX_OUT];
    logic [DW-1:0] slot_data  [MAX_OUT];

    logic [7:0]    inflight;
    logic [AW-1:0] head_addr;
    logic [AW-1:0] tag;
    logic [IW-1:0] sidx;
    logic          tag_ok;
    logic          retire;
    logic          issue;
    logic          accept;
    logic          drop;
    int unsigned   sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (retired == total) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == RUN);
        done      = (state == FIN);
        out_valid = (state == RUN) && slot_valid[hp];
        out_addr  = head_addr;
        out_data  = slot_data[hp];
    end

    always_comb begin
        head_addr = base + AW'(retired);
        inflight  = issued - retired;
        retire    = out_valid && out_ready;
        // a retirement in this cycle already frees a window place for the issue decision
        issue     = (state == RUN) && (issued < total) &&
                    ((inflight - {7'b0, retire}) < 8'(MAX_OUT));
        tag       = resp_addr - head_addr;
        tag_ok    = (32'(tag) < 32'(inflight));
        sum       = (32'(hp) + 32'(tag)) % MAX_OUT;
        sidx      = IW'(sum);
        accept    = (state == RUN) && resp_flag && tag_ok && !slot_valid[sidx];
        drop      = (state == RUN) && resp_flag && !accept;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_en   <= 1'b0;
            req_addr <= '0;
            base     <= '0;
            total    <= '0;
            issued   <= '0;
            retired  <= '0;
            hp       <= '0;
            err      <= 1'b0;
            for (int unsigned i = 0; i < MAX_OUT; i++) begin
                slot_valid[i] <= 1'b0;
                slot_data[i]  <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    req_en <= 1'b0;
                    if (start) begin
                        base    <= base_addr;
                        total   <= count;
                        retired <= '0;
                        hp      <= '0;
                        err     <= 1'b0;
                        for (int unsigned i = 0; i < MAX_OUT; i++) slot_valid[i] <= 1'b0;
                        // the first request leaves on the start edge so it appears one cycle later
                        if (count != 8'd0) begin
                            req_en   <= 1'b1;
                            req_addr <= base_addr;
                            issued   <= 8'd1;
                        end else begin
                            issued   <= '0;
                        end
                    end
                end
                RUN: begin
                    req_en <= issue;
                    if (issue) begin
                        req_addr <= base + AW'(issued);
                        issued   <= issued + 8'd1;
                    end
                    if (retire) begin
                        slot_valid[hp] <= 1'b0;
                        retired        <= retired + 8'd1;
                        hp             <= (32'(hp) == MAX_OUT - 1) ? '0 : hp + 1'b1;
                    end
                    if (accept) begin
                        slot_valid[sidx] <= 1'b1;
                        slot_data[sidx]  <= resp_data;
                    end
                    if (drop) err <= 1'b1;
                end
                default: req_en <= 1'b0;
            endcase
        end
    end

endmodule

// File: doc/mem_read_requester.md
# mem_read_requester

Initiator-side companion to the 16-entry read memory controller. Issues a programmed burst of read requests on the controller's `read_en`/`addr` port, never exceeding the controller's 4-entry request buffer. Collects the controller's out-of-order `flag`/`output_addr`/`data_out` responses and re-delivers them strictly in address-issue order on a valid/ready stream to the consumer.

## Interface
- `MAX_OUT`, 4, max outstanding requests; must be ≤ the controller buffer depth (4)
- `AW`, 8, address width
- `DW`, 8, data width
- `clk` in 1: single clock, all state on posedge
- `rst` in 1: asynchronous, active-high reset
- `start` in 1: begin burst; sampled only in IDLE
- `base_addr` in AW: first read address
- `count` in 8: number of reads (0..255)
- `req_en` out 1: to controller `read_en`
- `req_addr` out AW: to controller `addr`
- `resp_flag` in 1: controller `flag`, one-cycle strobe
- `resp_addr` in AW: controller `output_addr`
- `resp_data` in DW: controller `data_out`
- `out_valid` out 1, `out_addr` out AW, `out_data` out DW: in-order result stream
- `out_ready` in 1: consumer accept
- `busy` out 1: high in RUN
- `done` out 1: one-cycle pulse at burst end
- `err` out 1: sticky unexpected-response flag, cleared by `rst` or accepted `start`

## Operation
- States: IDLE, RUN, FIN.
- IDLE: `start`=1 latches `base_addr`/`count`, clears counters, slots, and `err` → RUN. Otherwise hold.
- RUN: counters `issued`, `retired` (8 b); `inflight` = `issued`−`retired` (0..MAX_OUT).
- Issue rule: if `issued`<`count` and `inflight`<MAX_OUT (after any same-cycle retirement), drive `req_en`=1, `req_addr`=`base`+`issued` (mod 2^AW), `issued`++. Max one request per cycle.
- Slots: MAX_OUT entries {valid, data} in a ring indexed from the head, where head address = `base`+`retired`.
- Response (`resp_flag`=1 in RUN):
  - tag = `resp_addr`−head address (mod 2^AW).
  - If tag<`inflight` and that slot is empty, store `resp_data` and set valid.
  - Otherwise drop the response and set `err`.
- Window addresses are always distinct, so tag matching is unambiguous.
- Output: `out_valid` = head slot valid; `out_addr` = head address; `out_data` = head data.
- On `out_valid`&&`out_ready`: clear the head slot, `retired`++, head advances.
- `retired`==`count` → FIN. `count`=0 goes straight to FIN.
- FIN: `done`=1 for one cycle → IDLE.
- `resp_flag` in IDLE/FIN is ignored; no `err`.
- `start` while not IDLE is ignored.

## Timing
- Reset values: `req_en`=0, `req_addr`=0, `out_valid`=0, `out_addr`=0, `out_data`=0, `busy`=0, `done`=0, `err`=0; state IDLE; all slots invalid.
- `req_en`/`req_addr` are registered.
  - `start` sampled at edge E → first `req_en` in cycle E+1.
  - Back-to-back requests until the window is full.
- Response captured at edge N. If it is the head, `out_valid` is high from cycle N+1.
- Same-cycle events:
  - Retirement frees a window place usable by the issue decision in that same cycle.
  - A response into a non-head slot and a head handshake may coincide; both take effect.
- `out_valid` holds with stable `out_addr`/`out_data` while `out_ready`=0. Issue continues while the window allows.
- Address wrap: `base`=254, `count`=4 issues 254, 255, 0, 1.
- `rst` mid-burst: immediate return to reset values. Responses arriving afterwards are ignored (IDLE).

## Test plan
- `count`=0, `start`=1 → no `req_en`; `done` pulses 2 cycles later; `busy` pulses 1 cycle.
- `base`=5, `count`=1; respond addr 5, data 47 → `out_valid` with `out_addr`=5, `out_data`=47; `done` pulses after handshake.
- `base`=0, `count`=4; responses in order 2,0,3,1 (data 69,33,11,14) → stream 33,14,69,11 on addr 0,1,2,3; first `out_valid` the cycle after addr 0 arrives.
- `count`=8, no responses → exactly 4 `req_en` pulses (addr 0..3), then stall. Return addr 0 with `out_ready`=1 → exactly one more request (addr 4).
- Window 0..3 outstanding: inject response addr 9, then a duplicate addr 1 → `err`=1 sticky; stream unaffected; `err` cleared by next `start`.
- `rst` asserted after 2 requests → all outputs at reset values asynchronously. A late response is ignored. A new `start` with `base`=254, `count`=4 → requests 254, 255, 0, 1.
